// File: rtl/puf_batch_driver_if.sv
// ---------------------------------------------------------------------------
// puf_batch_driver_if
// Challenge/response handshake between the batch driver and the PUF mapping
// block.
//   trigger    one-cycle request from the driver
//   challenge  challenge word, stable while trigger is high
//   pufDone    one-cycle completion pulse from the mapping block
//   pufData    response word, valid while pufDone is high
// Modports: master = batch driver, slave = mapping block.
// ---------------------------------------------------------------------------
interface puf_batch_driver_if #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 16
);
  logic                 trigger;
  logic [IN_WIDTH-1:0]  challenge;
  logic                 pufDone;
  logic [OUT_WIDTH-1:0] pufData;

  modport master (
    output trigger,
    output challenge,
    input  pufDone,
    input  pufData
  );

  modport slave (
    input  trigger,
    input  challenge,
    output pufDone,
    output pufData
  );
endinterface

// File: rtl/puf_batch_driver.sv
// ---------------------------------------------------------------------------
// puf_batch_driver
// Host-side initiator for the PUF mapping stage. A host start pulse launches
// a batch of consecutive challenges (seed, seed+1, ...); each response is
// stored in a response RAM that the host reads back by address.
// Ports:
//   clk, reset     single rising-edge clock, async active-high reset
//   start          host pulse beginning a batch (ignored while busy)
//   seed           first challenge, sampled on the accepted start
//   numChallenges  batch length 0..2^DEPTH_LOG2, saturated above that
//   puf            master side of the trigger/challenge/pufDone/pufData link
//   rdAddr/rdData  host read port, one cycle of read latency
//   busy           high from the accepted start until batchDone
//   batchDone      one-cycle pulse when a batch ends (normal/empty/aborted)
//   timeoutErr     sticky, set on a response timeout, cleared by next start
//   count          responses stored in the current or last batch
// ---------------------------------------------------------------------------
module puf_batch_driver #(
  parameter int IN_WIDTH   = 128,
  parameter int OUT_WIDTH  = 16,
  parameter int DEPTH_LOG2 = 6,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   seed,
  input  logic [DEPTH_LOG2:0]   numChallenges,
  puf_batch_driver_if.master    puf,
  input  logic [DEPTH_LOG2-1:0] rdAddr,
  output logic [OUT_WIDTH-1:0]  rdData,
  output logic                  busy,
  output logic                  batchDone,
  output logic                  timeoutErr,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] MAX_N  = CW'(DEPTH);
  // WAIT gives up once the counter would reach TIMEOUT-1, i.e. in the
  // cycle where it still holds TIMEOUT-2.
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STORE  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [IN_WIDTH-1:0]  challenge_q, challenge_d;
  logic [CW-1:0]        remain_q, remain_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 timeoutErr_q, timeoutErr_d;
  logic [OUT_WIDTH-1:0] resp_q, resp_d;
  logic [OUT_WIDTH-1:0] rdData_q, rdData_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 ram_we;
  logic [CW-1:0]        n_sat;

  logic [OUT_WIDTH-1:0] ram [0:DEPTH-1];

  assign n_sat = (numChallenges > MAX_N) ? MAX_N : numChallenges;

  assign puf.trigger   = (state_q == S_ISSUE);
  assign puf.challenge = challenge_q;
  assign busy          = (state_q != S_IDLE);
  assign batchDone     = (state_q == S_FINISH);
  assign timeoutErr    = timeoutErr_q;
  assign count         = count_q;
  assign rdData        = rdData_q;

  // Batch sequencer. A response arriving in the last timeout cycle takes
  // priority over the timeout abort.
  always_comb begin
    state_d      = state_q;
    challenge_d  = challenge_q;
    remain_d     = remain_q;
    count_d      = count_q;
    timeoutErr_d = timeoutErr_q;
    resp_d       = resp_q;
    tcnt_d       = tcnt_q;
    ram_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          challenge_d  = seed;
          remain_d     = n_sat;
          count_d      = '0;
          timeoutErr_d = 1'b0;
          state_d      = (n_sat == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        if (puf.pufDone) begin
          resp_d  = puf.pufData;
          state_d = S_STORE;
        end else if (tcnt_q == T_LAST) begin
          timeoutErr_d = 1'b1;
          state_d      = S_FINISH;
        end
      end
      S_STORE: begin
        ram_we      = 1'b1;
        count_d     = count_q + CW'(1);
        remain_d    = remain_q - CW'(1);
        challenge_d = challenge_q + IN_WIDTH'(1);
        state_d     = (remain_q == CW'(1)) ? S_FINISH : S_ISSUE;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Host read port reads every cycle; a same-cycle write shows up next read.
  always_comb begin
    rdData_d = ram[rdAddr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      challenge_q  <= '0;
      remain_q     <= '0;
      count_q      <= '0;
      timeoutErr_q <= 1'b0;
      resp_q       <= '0;
      rdData_q     <= '0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      challenge_q  <= challenge_d;
      remain_q     <= remain_d;
      count_q      <= count_d;
      timeoutErr_q <= timeoutErr_d;
      resp_q       <= resp_d;
      rdData_q     <= rdData_d;
      tcnt_q       <= tcnt_d;
    end
  end

  // Response RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[count_q[DEPTH_LOG2-1:0]] <= resp_q;
    end
  end

endmodule
